uart_tx_queue: RTL and testbench
================================

Name: uart_tx_queue

Overview:
Byte queue and launch sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the processor/MMIO side with single-cycle writes and buffers them in a FIFO. It hands them to the transmitter one at a time using the transmitter's tx_start / tx_busy / tx_done handshake, so software never waits on serial timing.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, minimum 2.
ADDR_W, $clog2(DEPTH), localparam; FIFO pointer width.

Ports:
clk  input  1  system clock (80 MHz)
rst  input  1  asynchronous active-high reset
wr_data  input  8  byte to enqueue
wr_en  input  1  enqueue strobe, one byte per cycle
ovf_clr  input  1  clears sticky overflow flag
full  output  1  FIFO holds DEPTH bytes
empty  output  1  FIFO holds 0 bytes
count  output  ADDR_W+1  bytes currently queued (excludes byte in flight)
overflow  output  1  sticky: a write arrived while full
tx_data  output  8  byte presented to transmitter
tx_start  output  1  one-cycle launch pulse to transmitter
tx_busy  input  1  transmitter busy (from transmitter)
tx_done  input  1  transmitter one-cycle completion pulse

Behaviour:
- Reset is asynchronous, active-high, and applies at any time including mid-frame. On reset: pointers=0, count=0, full=0, empty=1, overflow=0, tx_start=0, tx_data=8'h00, FSM=IDLE. The FIFO contents are not cleared.
- All outputs are registered. full, empty and count are derived from the registered count.
- Write: wr_en with full=0 stores wr_data at wr_ptr, increments wr_ptr (wraps modulo DEPTH) and increments count.
- Write with full=1 drops the byte and sets overflow. FIFO state is unchanged.
- overflow stays set until ovf_clr. If ovf_clr and an overflowing write occur in the same cycle, overflow stays set (set wins).
- The pop is internal, performed by the FSM. A push and a pop in the same cycle leave count unchanged. A push is accepted in the same cycle as a pop from a full FIFO only if full was 0 in that cycle; otherwise it is dropped.
- FSM states:
  - IDLE: if empty=0 and tx_busy=0, register tx_data<=mem[rd_ptr], set tx_start<=1, increment rd_ptr (wrapping), decrement count, and go to LAUNCH. Otherwise stay in IDLE.
  - LAUNCH: tx_start<=0 (pulse is exactly 1 cycle); go to WAIT_DONE.
  - WAIT_DONE: hold tx_data stable. On tx_done=1, go to IDLE.
  - Any illegal encoding goes to IDLE.
- Latency: wr_en at cycle N into an empty, idle queue gives count=1 at N+1 and tx_start=1 at N+2 with tx_data equal to the written byte.
- Back-to-back launch: tx_done at cycle M gives tx_start at M+2 at the earliest, and only if tx_busy=0 and empty=0.
- tx_data never changes between tx_start and the following tx_done.
- The tx_busy=1 guard in IDLE prevents launching over a transmission the queue did not start, for example after the queue alone was reset.
- The count width holds the value DEPTH without wrapping.

Optional Feature:
UART_TXQ_FLUSH_EN
- With the macro defined: an extra input port flush (1 bit) is added. flush=1 sets rd_ptr<=wr_ptr and count<=0 at the next edge, discarding all queued bytes. A concurrent wr_en is also discarded. An in-flight byte completes normally and the FSM is not disturbed.
- Without the macro: no flush port and no flush logic. The queue drains only through the transmitter.

Decomposition:
- Shared package uart_pkg holds:
  - CLK_FREQ (80_000_000) and BAUD_RATE (115200) defaults shared with the transmitter.
  - The queue FSM state encodings (IDLE=2'd0, LAUNCH=2'd1, WAIT_DONE=2'd2).
- One sub-module, uart_byte_fifo: synchronous single-clock FIFO with push/pop, full/empty/count and registered read data. It is parameterised by DEPTH and instantiated once.
- The FSM and overflow logic live in uart_tx_queue.

Test Plan:
- Reset, then write 8'hA5 at cycle N with a transmitter model idle -> count=1 at N+1; tx_start=1 for exactly one cycle at N+2 with tx_data=8'hA5; empty=1 after the pop.
- Write 8'h01..8'h04 back-to-back; model tx_done 10 cycles after each tx_start -> four tx_start pulses carrying 01,02,03,04 in order; each launch is at least 2 cycles after the prior tx_done; tx_data is stable in between.
- Hold tx_busy=1 with no tx_done and write 17 bytes at DEPTH=16 -> full=1, count=16, overflow=1, 17th byte absent from output; assert ovf_clr -> overflow=0.
- With FIFO full, perform wr_en in the same cycle as the IDLE pop -> write dropped, overflow=1, count=15 after the pop.
- Assert rst asynchronously in WAIT_DONE with 3 bytes queued -> all outputs return to reset values immediately, before the next clk edge; after release there is no tx_start until new writes arrive.
- With UART_TXQ_FLUSH_EN defined: queue 5 bytes during a transmission, then pulse flush -> count=0 and empty=1 next cycle; the in-flight byte still gets tx_done; no further tx_start follows.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: default clock/baud values and the TX queue launch FSM states.
package uart_pkg;

   localparam int CLK_FREQ  = 80_000_000;
   localparam int BAUD_RATE = 115200;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } txq_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Single-clock byte FIFO with registered count and an output register loaded on pop.
// Optional UART_TXQ_FLUSH_EN adds flush_i, which empties the queue in one cycle.
module uart_byte_fifo #(
   parameter int DEPTH = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              push_i,
   input  logic [7:0]        wr_data_i,
   input  logic              pop_i,
`ifdef UART_TXQ_FLUSH_EN
   input  logic              flush_i,
`endif
   output logic [7:0]        rd_data_o,
   output logic [ADDR_W:0]   count_o,
   output logic              full_o,
   output logic              empty_o
);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              push_ok, pop_ok;

   assign full_o    = (count_q == (ADDR_W+1)'(DEPTH));
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;
   assign rd_data_o = rd_data_q;

   always_comb begin
`ifdef UART_TXQ_FLUSH_EN
      push_ok = push_i && !full_o && !flush_i;
      pop_ok  = pop_i && !empty_o && !flush_i;
`else
      push_ok = push_i && !full_o;
      pop_ok  = pop_i && !empty_o;
`endif
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      rd_data_d = rd_data_q;
      count_d   = count_q + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
      if (push_ok) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (pop_ok) begin
         rd_data_d = mem_q[rd_ptr_q];
         rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      end
`ifdef UART_TXQ_FLUSH_EN
      // Flush drops everything queued; the output register keeps the in-flight byte.
      if (flush_i) begin
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         rd_data_q <= 8'h00;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         rd_data_q <= rd_data_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk_i) begin
      if (push_ok) begin
         mem_q[wr_ptr_q] <= wr_data_i;
      end
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter through the tx_start/tx_busy/tx_done handshake.
// Defining UART_TXQ_FLUSH_EN adds a flush input that discards all queued bytes.
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH = 16,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        wr_data,
   input  logic              wr_en,
   input  logic              ovf_clr,
`ifdef UART_TXQ_FLUSH_EN
   input  logic              flush,
`endif
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              overflow,
   output logic [7:0]        tx_data,
   output logic              tx_start,
   input  logic              tx_busy,
   input  logic              tx_done
);

   txq_state_e state_q, state_d;
   logic       tx_start_q, tx_start_d;
   logic       overflow_q, overflow_d;
   logic       launch_ok;
   logic       pop;

   uart_byte_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk_i     (clk),
      .rst_i     (rst),
      .push_i    (wr_en),
      .wr_data_i (wr_data),
      .pop_i     (pop),
`ifdef UART_TXQ_FLUSH_EN
      .flush_i   (flush),
`endif
      .rd_data_o (tx_data),
      .count_o   (count),
      .full_o    (full),
      .empty_o   (empty)
   );

   // tx_busy also blocks launches over a frame this queue did not start.
`ifdef UART_TXQ_FLUSH_EN
   assign launch_ok = !empty && !tx_busy && !flush;
`else
   assign launch_ok = !empty && !tx_busy;
`endif

   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (launch_ok) begin
               pop        = 1'b1;
               tx_start_d = 1'b1;
               state_d    = LAUNCH;
            end
         end
         LAUNCH: begin
            state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (tx_done) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // A write that overflows in the same cycle as ovf_clr keeps the flag set.
   always_comb begin
      overflow_d = overflow_q;
      if (ovf_clr) begin
         overflow_d = 1'b0;
      end
      if (wr_en && full) begin
         overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         overflow_q <= overflow_d;
      end
   end

   assign tx_start = tx_start_q;
   assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Self-checking bench for uart_tx_queue with a behavioural transmitter and byte-order scoreboard.
// Define UART_TXQ_FLUSH_EN to include the flush scenario.
module tb_uart_tx_queue;

   localparam int DEPTH = 16;
   localparam int AW    = $clog2(DEPTH);

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    wr_data = 8'h00;
   logic          wr_en = 1'b0;
   logic          ovf_clr = 1'b0;
`ifdef UART_TXQ_FLUSH_EN
   logic          flush = 1'b0;
`endif
   logic          full, empty, overflow, tx_start;
   logic [AW:0]   count;
   logic [7:0]    tx_data;
   logic          tx_busy;
   logic          tx_done = 1'b0;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // transmitter model state and observation logs
   int            xm_lat  = 4;
   logic          xm_hold = 1'b0;
   logic          xm_act  = 1'b0;
   int            xm_left = 0;
   logic          inflight = 1'b0;
   logic          prev_start = 1'b0;
   logic [7:0]    held = 8'h00;
   int            width_bad = 0;
   int            data_chg  = 0;
   int            start_cyc[$];
   logic [7:0]    start_data[$];
   int            done_cyc[$];

   assign tx_busy = xm_hold | xm_act;

   uart_tx_queue #(.DEPTH(DEPTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_data  (wr_data),
      .wr_en    (wr_en),
      .ovf_clr  (ovf_clr),
`ifdef UART_TXQ_FLUSH_EN
      .flush    (flush),
`endif
      .full     (full),
      .empty    (empty),
      .count    (count),
      .overflow (overflow),
      .tx_data  (tx_data),
      .tx_start (tx_start),
      .tx_busy  (tx_busy),
      .tx_done  (tx_done)
   );

   initial forever #5 clk = ~clk;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

   // Transmitter: busy for xm_lat cycles after each tx_start, then a one-cycle tx_done.
   initial forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (rst) begin
         xm_act = 1'b0; xm_left = 0; inflight = 1'b0; prev_start = 1'b0;
      end else begin
         if (tx_start === 1'b1) begin
            if (prev_start) width_bad++;
            start_cyc.push_back(cyc);
            start_data.push_back(tx_data);
         end
         if (inflight && tx_data !== held) data_chg++;
         if (xm_left > 0) begin
            xm_left--;
            if (xm_left == 0) begin
               tx_done = 1'b1; xm_act = 1'b0; inflight = 1'b0;
               done_cyc.push_back(cyc);
            end
         end else if (tx_start === 1'b1) begin
            xm_left = xm_lat; xm_act = 1'b1; inflight = 1'b1; held = tx_data;
         end
         prev_start = tx_start;
      end
   end

   task automatic do_reset();
      wr_en = 1'b0; ovf_clr = 1'b0; xm_hold = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got=%b exp=0", full); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got=%b exp=1", empty); end
      checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b exp=0", tx_start); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h exp=00", tx_data); end
      rst = 1'b0;
   endtask

   task automatic test_latency();
      int d0;
      do_reset();
      xm_lat = 4;
      d0 = done_cyc.size();
      @(negedge clk); wr_data = 8'hA5; wr_en = 1'b1;
      @(negedge clk); wr_en = 1'b0;
      checks++; if (count !== 5'd1) begin errors++; $display("FAIL lat_count_n1 got=%0d exp=1", count); end
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL lat_start_n1 got=%b exp=0", tx_start); end
      @(negedge clk);
      checks++; if (tx_start !== 1'b1) begin errors++; $display("FAIL lat_start_n2 got=%b exp=1", tx_start); end
      checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL lat_data got=%h exp=a5", tx_data); end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL lat_empty_after_pop got=%b exp=1", empty); end
      @(negedge clk);
      checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL lat_pulse_width got=%b exp=0", tx_start); end
      for (int i = 0; i < 30 && done_cyc.size() < d0 + 1; i++) @(negedge clk);
      checks++; if (done_cyc.size() != d0 + 1) begin errors++; $display("FAIL lat_done_count got=%0d exp=1", done_cyc.size() - d0); end
   endtask

   task automatic test_back_to_back();
      int s0, d0, wb0, dc0;
      do_reset();
      xm_lat = 10;
      s0 = start_data.size(); d0 = done_cyc.size(); wb0 = width_bad; dc0 = data_chg;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk); wr_data = 8'(i); wr_en = 1'b1;
      end
      @(negedge clk); wr_en = 1'b0;
      for (int i = 0; i < 150 && done_cyc.size() < d0 + 4; i++) @(negedge clk);
      checks++; if (start_data.size() != s0 + 4) begin errors++; $display("FAIL b2b_start_count got=%0d exp=4", start_data.size() - s0); end
      for (int i = 0; i < 4; i++) begin
         if (s0 + i < start_data.size()) begin
            checks++;
            if (start_data[s0+i] !== 8'(i + 1)) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, start_data[s0+i], 8'(i + 1)); end
         end
         if (i > 0 && s0 + i < start_cyc.size() && d0 + i - 1 < done_cyc.size()) begin
            checks++;
            if (start_cyc[s0+i] - done_cyc[d0+i-1] < 2) begin errors++; $display("FAIL b2b_gap[%0d] got=%0d exp>=2", i, start_cyc[s0+i] - done_cyc[d0+i-1]); end
         end
      end
      checks++; if (width_bad != wb0) begin errors++; $display("FAIL b2b_pulse_width got=%0d long pulses exp=0", width_bad - wb0); end
      checks++; if (data_chg != dc0) begin errors++; $display("FAIL b2b_data_stable got=%0d changes exp=0", data_chg - dc0); end
   endtask

   task automatic test_overflow();
      logic [7:0] exp[17];
      int s0, d0;
      do_reset();
      xm_hold = 1'b1; xm_lat = 2;
      s0 = start_data.size(); d0 = done_cyc.size();
      for (int i = 0; i < 17; i++) begin
         exp[i] = 8'($urandom_range(0, 255));
         @(negedge clk); wr_data = exp[i]; wr_en = 1'b1;
      end
      @(negedge clk); wr_en = 1'b0;
      checks++; if (full !== 1'b1) begin errors++; $display("FAIL ovf_full got=%b exp=1", full); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count got=%0d exp=16", count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
      checks++; if (start_data.size() != s0) begin errors++; $display("FAIL ovf_no_launch_while_busy got=%0d exp=0", start_data.size() - s0); end
      ovf_clr = 1'b1;
      @(negedge clk); ovf_clr = 1'b0;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
      ovf_clr = 1'b1; wr_en = 1'b1; wr_data = 8'h5A;
      @(negedge clk); ovf_clr = 1'b0; wr_en = 1'b0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins got=%b exp=1", overflow); end
      checks++; if (count !== 5'd16) begin errors++; $display("FAIL ovf_count_unchanged got=%0d exp=16", count); end
      ovf_clr = 1'b1;
      @(negedge clk); ovf_clr = 1'b0;
      xm_hold = 1'b0;
      for (int i = 0; i < 300 && done_cyc.size() < d0 + 16; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      checks++; if (start_data.size() != s0 + 16) begin errors++; $display("FAIL ovf_drain_count got=%0d exp=16", start_data.size() - s0); end
      for (int i = 0; i < 16 && s0 + i < start_data.size(); i++) begin
         checks++;
         if (start_data[s0+i] !== exp[i]) begin errors++; $display("FAIL ovf_drain_data[%0d] got=%h exp=%h", i, start_data[s0+i], exp[i]); end
      end
      checks++; if (empty !== 1'b1) begin errors++; $display("FAIL ovf_drained_empty got=%b exp=1", empty); end
   endtask

   task automatic test_full_pop_write();
      logic [7:0] exp[16];
      int s0, d0;
      do_reset();
      xm_hold = 1'b1; xm_lat = 2;
      s0 = start_data.size(); d0 = done_cyc.size();
      for (int i = 0; i < 16; i++) begin
         exp[i] = 8'($urandom_range(0, 255));
         @(negedge clk); wr_data = exp[i]; wr_en = 1'b1;
      end
      @(negedge clk); wr_en = 1'b0;
      checks++; if (full !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL fpw_prefill got full=%b ovf=%b exp full=1 ovf=0", full, overflow); end
      @(negedge clk); xm_hold = 1'b0; wr_en = 1'b1; wr_data = ~exp[0];
      @(negedge clk); wr_en = 1'b0;
      checks++; if (count !== 5'd15) begin errors++; $display("FAIL fpw_count got=%0d exp=15", count); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL fpw_overflow got=%b exp=1", overflow); end
      checks++; if (tx_start !== 1'b1 || tx_data !== exp[0]) begin errors++; $display("FAIL fpw_launch got start=%b data=%h exp start=1 data=%h", tx_start, tx_data, exp[0]); end
      for (int i = 0; i < 300 && done_cyc.size() < d0 + 16; i++) @(negedge clk);
      repeat (10) @(negedge clk);
      checks++; if (start_data.size() != s0 + 16) begin errors++; $display("FAIL fpw_drain_count got=%0d exp=16", start_data.size() - s0); end
      for (int i = 0; i < 16 && s0 + i < start_data.size(); i++) begin
         checks++;
         if (start_data[s0+i] !== exp[i]) begin errors++; $display("FAIL fpw_drain_data[%0d] got=%h exp=%h", i, start_data[s0+i], exp[i]); end
      end
   endtask

   task automatic test_async_reset();
      logic [7:0] b;
      int s0, d0;
      do_reset();
      xm_lat = 20;
      s0 = start_data.size();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); wr_data = 8'($urandom_range(1, 255)); wr_en = 1'b1;
      end
      @(negedge clk); wr_en = 1'b0;
      for (int i = 0; i < 20 && start_data.size() < s0 + 1; i++) @(negedge clk);
      repeat (4) @(negedge clk);
      checks++; if (count !== 5'd3) begin errors++; $display("FAIL ar_count_before got=%0d exp=3", count); end
      @(posedge clk); #2 rst = 1'b1;
      #1;
      checks++; if (count !== 5'd0 || empty !== 1'b1 || full !== 1'b0) begin errors++; $display("FAIL ar_flags got count=%0d empty=%b full=%b exp 0/1/0", count, empty, full); end
      checks++; if (tx_start !== 1'b0 || overflow !== 1'b0) begin errors++; $display("FAIL ar_ctrl got start=%b ovf=%b exp 0/0", tx_start, overflow); end
      checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL ar_tx_data got=%h exp=00", tx_data); end
      @(negedge clk); #1 rst = 1'b0;
      s0 = start_data.size(); d0 = done_cyc.size();
      repeat (30) @(negedge clk);
      checks++; if (start_data.size() != s0) begin errors++; $display("FAIL ar_no_launch got=%0d exp=0", start_data.size() - s0); end
      xm_lat = 3; b = 8'($urandom_range(0, 255));
      @(negedge clk); wr_data = b; wr_en = 1'b1;
      @(negedge clk); wr_en = 1'b0;
      for (int i = 0; i < 20 && done_cyc.size() < d0 + 1; i++) @(negedge clk);
      checks++; if (start_data.size() != s0 + 1) begin errors++; $display("FAIL ar_relaunch_count got=%0d exp=1", start_data.size() - s0); end
      else begin
         checks++; if (start_data[s0] !== b) begin errors++; $display("FAIL ar_relaunch_data got=%h exp=%h", start_data[s0], b); end
      end
   endtask

   task automatic test_random();
      logic [7:0] exp[$];
      int s0, d0, wb0, dc0, len;
      do_reset();
      for (int burst = 0; burst < 6; burst++) begin
         len = $urandom_range(1, DEPTH);
         xm_lat = $urandom_range(1, 6);
         exp.delete();
         s0 = start_data.size(); d0 = done_cyc.size(); wb0 = width_bad; dc0 = data_chg;
         for (int i = 0; i < len; i++) begin
            @(negedge clk); wr_data = 8'($urandom_range(0, 255)); wr_en = 1'b1;
            exp.push_back(wr_data);
            if ($urandom_range(0, 2) == 0) begin
               @(negedge clk); wr_en = 1'b0;
            end
         end
         @(negedge clk); wr_en = 1'b0;
         for (int i = 0; i < 400 && done_cyc.size() < d0 + len; i++) @(negedge clk);
         repeat (3) @(negedge clk);
         checks++; if (start_data.size() != s0 + len) begin errors++; $display("FAIL rnd%0d_count got=%0d exp=%0d", burst, start_data.size() - s0, len); end
         for (int i = 0; i < len && s0 + i < start_data.size(); i++) begin
            checks++;
            if (start_data[s0+i] !== exp[i]) begin errors++; $display("FAIL rnd%0d_data[%0d] got=%h exp=%h", burst, i, start_data[s0+i], exp[i]); end
            if (i > 0 && d0 + i - 1 < done_cyc.size()) begin
               checks++;
               if (start_cyc[s0+i] - done_cyc[d0+i-1] < 2) begin errors++; $display("FAIL rnd%0d_gap[%0d] got=%0d exp>=2", burst, i, start_cyc[s0+i] - done_cyc[d0+i-1]); end
            end
         end
         checks++; if (width_bad != wb0 || data_chg != dc0) begin errors++; $display("FAIL rnd%0d_handshake got long=%0d chg=%0d exp 0/0", burst, width_bad - wb0, data_chg - dc0); end
         checks++; if (empty !== 1'b1 || overflow !== 1'b0) begin errors++; $display("FAIL rnd%0d_end got empty=%b ovf=%b exp 1/0", burst, empty, overflow); end
      end
   endtask

`ifdef UART_TXQ_FLUSH_EN
   task automatic test_flush();
      int s0, d0, dc0;
      do_reset();
      xm_lat = 30;
      s0 = start_data.size(); d0 = done_cyc.size(); dc0 = data_chg;
      @(negedge clk); wr_data = 8'($urandom_range(0, 255)); wr_en = 1'b1;
      @(negedge clk); wr_en = 1'b0;
      for (int i = 0; i < 10 && start_data.size() < s0 + 1; i++) @(negedge clk);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); wr_data = 8'($urandom_range(0, 255)); wr_en = 1'b1;
      end
      @(negedge clk); wr_en = 1'b0;
      checks++; if (count !== 5'd5) begin errors++; $display("FAIL fl_count_before got=%0d exp=5", count); end
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      checks++; if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL fl_cleared got count=%0d empty=%b exp 0/1", count, empty); end
      for (int i = 0; i < 60 && done_cyc.size() < d0 + 1; i++) @(negedge clk);
      checks++; if (done_cyc.size() != d0 + 1) begin errors++; $display("FAIL fl_inflight_done got=%0d exp=1", done_cyc.size() - d0); end
      repeat (20) @(negedge clk);
      checks++; if (start_data.size() != s0 + 1) begin errors++; $display("FAIL fl_no_more_launch got=%0d exp=1", start_data.size() - s0); end
      checks++; if (data_chg != dc0) begin errors++; $display("FAIL fl_data_stable got=%0d exp=0", data_chg - dc0); end
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_back_to_back();
      test_overflow();
      test_full_pop_write();
      test_async_reset();
      test_random();
`ifdef UART_TXQ_FLUSH_EN
      test_flush();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
